result_checker: RTL
===================

# result_checker

Synthesizable response checker for processing-element benches and on-chip self-test. It receives expected results through a small FIFO and compares them in order, bit-exact, against the DUT output stream. It keeps pass and fail counts, records the first mismatch, and flags underflow, so one module replaces the per-bench expected-result comparison with a uniform, countable verdict.

## Interface
Parameters:
- DATA_W, 16, width of compared results
- DEPTH, 8, expected-value FIFO depth; power of two, at least 2
- CNT_W, 16, width of counters and index

Ports:
- clk_i  in  1  clock; all registers update on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse: clear counters, flush FIFO, enter RUN
- end_i  in  1  one-cycle pulse: no further expected values; finish once FIFO drains
- exp_valid_i  in  1  expected value offered
- exp_data_i  in  DATA_W  expected value
- exp_ready_o  out  1  FIFO accepts a push this cycle
- dut_valid_i  in  1  DUT result present this cycle (no backpressure)
- dut_data_i  in  DATA_W  DUT result
- correct_o  out  1  result of the most recent comparison
- pass_cnt_o  out  CNT_W  matching comparisons
- fail_cnt_o  out  CNT_W  mismatching comparisons
- first_fail_idx_o  out  CNT_W  0-based comparison index of the first mismatch
- first_fail_exp_o  out  DATA_W  expected value at the first mismatch
- first_fail_got_o  out  DATA_W  DUT value at the first mismatch
- underflow_o  out  1  sticky: a DUT result arrived while the FIFO was empty
- busy_o  out  1  state is RUN
- done_o  out  1  state is DONE

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Transitions:
  - start_i in any state goes to RUN, clears all counters, first-fail registers, correct_o, underflow_o and end_pending, and empties the FIFO.
  - end_i in RUN sets end_pending.
  - In RUN, end_pending high with the FIFO empty and no pop this cycle goes to DONE.
  - DONE holds until start_i or reset.
- Push:
  - exp_ready_o = RUN and FIFO not full.
  - A push happens when exp_valid_i and exp_ready_o are both high.
  - exp_valid_i while full is dropped silently; the producer must honour ready.
- Compare:
  - In RUN, dut_valid_i with the FIFO non-empty pops the head and compares it with dut_data_i using bit-exact equality.
  - A match increments pass_cnt_o. A mismatch increments fail_cnt_o.
  - The comparison index (number of prior comparisons since start) increments on every compare.
  - On the first mismatch only, first_fail_idx_o, first_fail_exp_o and first_fail_got_o are captured.
- Underflow: dut_valid_i in RUN with the FIFO empty sets underflow_o. No compare takes place and no counter moves.
- dut_valid_i in IDLE or DONE is ignored.
- Counters and the index saturate at 2^CNT_W-1 and never wrap.
- Simultaneous push and pop with the FIFO non-empty are both performed and the occupancy is unchanged.
- There is no bypass: a push into an empty FIFO is not visible to a pop in the same cycle, so that case is an underflow.
- Simultaneous end_i and start_i: start_i wins and end_pending stays clear.

## Timing
- Reset values: all outputs 0, except exp_ready_o, which is 0 because the state is IDLE. FIFO is empty.
- An asynchronous reset assertion mid-RUN clears everything immediately and loses FIFO contents.
- exp_ready_o and busy_o are combinational from state and occupancy.
- Every other output is registered. A compare at edge N updates correct_o, the counters and the first-fail fields, visible after edge N.
- A value pushed at edge N can be popped from edge N+1 onward.
- done_o rises one cycle after the edge on which the last pending compare completed, provided end_pending is set.
- After start_i at edge N, the state is RUN and all outputs are cleared from edge N onward.

## Test plan
- Reset then start_i; push 3, 7, 9; DUT returns 3, 7, 9; end_i -> pass_cnt 3, fail_cnt 0, correct_o 1, done_o 1, underflow 0.
- Push 0x0010, 0x0020, 0x0030; DUT returns 0x0010, 0x0021, 0x0031 -> pass 1, fail 2, first_fail_idx 1, first_fail_exp 0x0020, first_fail_got 0x0021.
- DEPTH=8: hold exp_valid_i for 10 cycles with no DUT results -> exp_ready_o falls after 8 pushes; the last 2 values are not stored; occupancy 8.
- dut_valid_i with the FIFO empty, including the same cycle as the first push -> underflow_o 1 and stays 1; counters unchanged; a later compare proceeds normally.
- end_i with 2 entries still queued -> done_o stays 0 until both are compared, then rises; a following start_i clears all outputs and returns busy_o 1.
- Assert rst_i mid-RUN with a non-empty FIFO -> all outputs 0 immediately, IDLE; dut_valid_i is ignored until start_i.

Source files
------------

// File: rtl/result_checker.sv
// result_checker: in-order, bit-exact response checker. Expected values are
// queued in a small FIFO and popped against the DUT result stream. It keeps
// pass/fail counts, records the first mismatch and flags underflow.
module result_checker #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              end_i,
    input  logic              exp_valid_i,
    input  logic [DATA_W-1:0] exp_data_i,
    output logic              exp_ready_o,
    input  logic              dut_valid_i,
    input  logic [DATA_W-1:0] dut_data_i,
    output logic              correct_o,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic [CNT_W-1:0]  first_fail_idx_o,
    output logic [DATA_W-1:0] first_fail_exp_o,
    output logic [DATA_W-1:0] first_fail_got_o,
    output logic              underflow_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      L_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] L_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_end_pending;

    logic [CNT_W-1:0]  r_pass_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_ff_idx;
    logic [DATA_W-1:0] r_ff_exp;
    logic [DATA_W-1:0] r_ff_got;
    logic              r_correct;
    logic              r_underflow;

    logic              w_run;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_uflow;
    logic [DATA_W-1:0] w_head;
    logic              w_match;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == L_MAX) ? v : v + 1'b1;
    endfunction

    assign w_run   = (r_state == ST_RUN);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_FULL);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_match = (w_head == dut_data_i);

    // start_i flushes the FIFO, so a push or pop in that cycle is discarded.
    assign w_push  = exp_valid_i && exp_ready_o && !start_i;
    assign w_pop   = w_run && dut_valid_i && !w_empty && !start_i;
    assign w_uflow = w_run && dut_valid_i && w_empty && !start_i;

    assign exp_ready_o      = w_run && !w_full;
    assign busy_o           = w_run;
    assign done_o           = (r_state == ST_DONE);
    assign correct_o        = r_correct;
    assign pass_cnt_o       = r_pass_cnt;
    assign fail_cnt_o       = r_fail_cnt;
    assign first_fail_idx_o = r_ff_idx;
    assign first_fail_exp_o = r_ff_exp;
    assign first_fail_got_o = r_ff_got;
    assign underflow_o      = r_underflow;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: start_i wins everywhere; RUN finishes once end is pending and the FIFO has drained.
    always_comb begin
        w_state_nxt = r_state;
        if (start_i) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (r_end_pending && w_empty && !w_pop) w_state_nxt = ST_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Expected-value storage; contents are don't-care outside the valid window.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= exp_data_i;
    end

    // FIFO pointers, occupancy and end-pending flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_end_pending <= 1'b0;
        end else if (start_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_end_pending <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (end_i && w_run) r_end_pending <= 1'b1;
        end
    end

    // Comparison results, counters, first-mismatch capture and sticky underflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_idx       <= '0;
            r_ff_idx    <= '0;
            r_ff_exp    <= '0;
            r_ff_got    <= '0;
            r_correct   <= 1'b0;
            r_underflow <= 1'b0;
        end else if (start_i) begin
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_idx       <= '0;
            r_ff_idx    <= '0;
            r_ff_exp    <= '0;
            r_ff_got    <= '0;
            r_correct   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_correct <= w_match;
                r_idx     <= sat_inc(r_idx);
                if (w_match) begin
                    r_pass_cnt <= sat_inc(r_pass_cnt);
                end else begin
                    r_fail_cnt <= sat_inc(r_fail_cnt);
                    // A saturating fail count never returns to zero, so this marks the first mismatch.
                    if (r_fail_cnt == '0) begin
                        r_ff_idx <= r_idx;
                        r_ff_exp <= w_head;
                        r_ff_got <= dut_data_i;
                    end
                end
            end
            if (w_uflow) r_underflow <= 1'b1;
        end
    end

endmodule
